// File: rtl/kip_pkg.sv
// Shared definitions for the KIP ingress merger slice.
// Holds the AXIS widths of the KIP return path, the beat record carried through the
// output register, the arbiter state encoding and the round-robin source tag.
package kip_pkg;

  localparam int unsigned AXIS_DATA_WIDTH      = 512;
  localparam int unsigned AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8;
  // tuser: [63:32] port info, [31:0] source IP
  localparam int unsigned AXIS_KIP_TUSER_WIDTH = 64;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]      data;
    logic [AXIS_KEEP_WIDTH-1:0]      keep;
    logic [AXIS_KIP_TUSER_WIDTH-1:0] tuser;
    logic                            last;
  } kip_beat_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_GS = 2'd1,
    GRANT_NB = 2'd2
  } merger_state_t;

  // Names the source that won the most recent arbitration.
  typedef enum logic {
    SRC_GS = 1'b0,
    SRC_NB = 1'b1
  } kip_src_t;

endpackage

// File: rtl/kip_ingress_merger_if.sv
// KIP AXI-Stream bundle (tvalid/tready/tdata/tkeep/tuser/tlast).
// master: drives tvalid, tdata, tkeep, tuser, tlast; receives tready.
// slave:  receives tvalid, tdata, tkeep, tuser, tlast; drives tready.
interface kip_ingress_merger_if;
  import kip_pkg::*;

  logic                            tvalid;
  logic                            tready;
  logic [AXIS_DATA_WIDTH-1:0]      tdata;
  logic [AXIS_KEEP_WIDTH-1:0]      tkeep;
  logic [AXIS_KIP_TUSER_WIDTH-1:0] tuser;
  logic                            tlast;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/kip_axis_reg_slice.sv
// Single-entry AXIS register stage with valid/ready.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  upstream handshake, in_beat is the incoming beat
//   out_valid/out_ready downstream handshake, out_beat is the registered beat
// in_ready is combinational from out_ready (no skid buffer): a new beat is taken when
// the register is empty or is being drained in the same cycle.
module kip_axis_reg_slice
  import kip_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  kip_beat_t in_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output kip_beat_t out_beat
);

  logic      valid_q;
  kip_beat_t beat_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_beat  = beat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      beat_q  <= in_beat;
    end else if (out_ready) begin
      // Drained with nothing new behind it: clear the fields as well as valid.
      valid_q <= 1'b0;
      beat_q  <= '0;
    end
  end

endmodule

// File: rtl/kip_ingress_merger.sv
// KIP ingress merger: return-path counterpart of the KIP router.
// Merges the GULF-Stream (remote) and control TX network bridge (local loopback) streams
// into one stream for the kernels with packet-atomic round-robin arbitration, one
// registered output stage and per-source packet counters.
// Ports:
//   i_clk, i_ap_rst      clock, synchronous active-high reset
//   from_gs              AXIS slave from GULF-Stream
//   from_tx_nb           AXIS slave from control TX network bridge
//   to_kernels           AXIS master to kernels (registered)
//   o_gs_pkt_count       packets forwarded from GS (wraps)
//   o_tx_nb_pkt_count    packets forwarded from TX NB (wraps)
module kip_ingress_merger
  import kip_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_ap_rst,
  kip_ingress_merger_if.slave   from_gs,
  kip_ingress_merger_if.slave   from_tx_nb,
  kip_ingress_merger_if.master  to_kernels,
  output logic [CNT_WIDTH-1:0]  o_gs_pkt_count,
  output logic [CNT_WIDTH-1:0]  o_tx_nb_pkt_count
);

  merger_state_t state_q, state_d;
  kip_src_t      rr_last_q, rr_last_d;

  logic [CNT_WIDTH-1:0] gs_cnt_q, gs_cnt_d;
  logic [CNT_WIDTH-1:0] nb_cnt_q, nb_cnt_d;

  kip_beat_t gs_beat, nb_beat, sel_beat, out_beat;
  logic      sel_valid, slice_ready, out_valid;
  logic      accept;

  assign gs_beat = '{data: from_gs.tdata, keep: from_gs.tkeep,
                     tuser: from_gs.tuser, last: from_gs.tlast};
  assign nb_beat = '{data: from_tx_nb.tdata, keep: from_tx_nb.tkeep,
                     tuser: from_tx_nb.tuser, last: from_tx_nb.tlast};

  // Source mux and tready gating: only the granted source ever sees tready.
  always_comb begin
    sel_valid        = 1'b0;
    sel_beat         = '0;
    from_gs.tready   = 1'b0;
    from_tx_nb.tready = 1'b0;
    unique case (state_q)
      GRANT_GS: begin
        sel_valid      = from_gs.tvalid;
        sel_beat       = gs_beat;
        from_gs.tready = slice_ready;
      end
      GRANT_NB: begin
        sel_valid         = from_tx_nb.tvalid;
        sel_beat          = nb_beat;
        from_tx_nb.tready = slice_ready;
      end
      default: ;
    endcase
  end

  assign accept = sel_valid && slice_ready;

  // Arbiter: the grant is held until the tlast beat is accepted, even across gaps.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gs_cnt_d  = gs_cnt_q;
    nb_cnt_d  = nb_cnt_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the source that did not win last time goes first.
        if (from_gs.tvalid && (!from_tx_nb.tvalid || rr_last_q == SRC_NB)) begin
          state_d   = GRANT_GS;
          rr_last_d = SRC_GS;
        end else if (from_tx_nb.tvalid) begin
          state_d   = GRANT_NB;
          rr_last_d = SRC_NB;
        end
      end
      GRANT_GS: begin
        if (accept && sel_beat.last) begin
          state_d  = IDLE;
          gs_cnt_d = gs_cnt_q + CNT_WIDTH'(1);
        end
      end
      GRANT_NB: begin
        if (accept && sel_beat.last) begin
          state_d  = IDLE;
          nb_cnt_d = nb_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state_q   <= IDLE;
      rr_last_q <= SRC_NB;
      gs_cnt_q  <= '0;
      nb_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gs_cnt_q  <= gs_cnt_d;
      nb_cnt_q  <= nb_cnt_d;
    end
  end

  kip_axis_reg_slice u_out_slice (
    .clk       (i_clk),
    .rst       (i_ap_rst),
    .in_valid  (sel_valid),
    .in_ready  (slice_ready),
    .in_beat   (sel_beat),
    .out_valid (out_valid),
    .out_ready (to_kernels.tready),
    .out_beat  (out_beat)
  );

  assign to_kernels.tvalid = out_valid;
  assign to_kernels.tdata  = out_beat.data;
  assign to_kernels.tkeep  = out_beat.keep;
  assign to_kernels.tuser  = out_beat.tuser;
  assign to_kernels.tlast  = out_beat.last;

  assign o_gs_pkt_count    = gs_cnt_q;
  assign o_tx_nb_pkt_count = nb_cnt_q;

endmodule

// File: tb/tb_kip_ingress_merger.sv
// Scoreboard bench for kip_ingress_merger: scenarios push hand-ordered expected beats,
// a negedge monitor pops and compares every beat handed to the kernels.
module tb_kip_ingress_merger;
  import kip_pkg::*;

  localparam int unsigned CW = 4;

  typedef struct {
    logic [AXIS_DATA_WIDTH-1:0]      d;
    logic [AXIS_KEEP_WIDTH-1:0]      k;
    logic [AXIS_KIP_TUSER_WIDTH-1:0] u;
    logic                            l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kready = 1'b1;

  logic                            drv_valid [2];
  logic [AXIS_DATA_WIDTH-1:0]      drv_data  [2];
  logic [AXIS_KEEP_WIDTH-1:0]      drv_keep  [2];
  logic [AXIS_KIP_TUSER_WIDTH-1:0] drv_user  [2];
  logic                            drv_last  [2];
  logic                            rdy       [2];

  logic [CW-1:0] gs_cnt, nb_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  kip_ingress_merger_if gs_if ();
  kip_ingress_merger_if nb_if ();
  kip_ingress_merger_if k_if ();

  assign gs_if.tvalid = drv_valid[0];
  assign gs_if.tdata  = drv_data[0];
  assign gs_if.tkeep  = drv_keep[0];
  assign gs_if.tuser  = drv_user[0];
  assign gs_if.tlast  = drv_last[0];
  assign nb_if.tvalid = drv_valid[1];
  assign nb_if.tdata  = drv_data[1];
  assign nb_if.tkeep  = drv_keep[1];
  assign nb_if.tuser  = drv_user[1];
  assign nb_if.tlast  = drv_last[1];
  assign rdy[0]       = gs_if.tready;
  assign rdy[1]       = nb_if.tready;
  assign k_if.tready  = kready;

  kip_ingress_merger #(.CNT_WIDTH(CW)) dut (
    .i_clk             (clk),
    .i_ap_rst          (rst),
    .from_gs           (gs_if),
    .from_tx_nb        (nb_if),
    .to_kernels        (k_if),
    .o_gs_pkt_count    (gs_cnt),
    .o_tx_nb_pkt_count (nb_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [AXIS_DATA_WIDTH-1:0] mk_data(int src, logic [7:0] tag, int b);
    logic [AXIS_DATA_WIDTH-1:0] d;
    d        = {64{8'h0F}};
    d[7:0]   = 8'(b);
    d[15:8]  = tag;
    d[23:16] = 8'(src);
    return d;
  endfunction

  function automatic logic [AXIS_KEEP_WIDTH-1:0] mk_keep(logic last);
    return last ? 64'h0000_00FF_FFFF_FFFF : {AXIS_KEEP_WIDTH{1'b1}};
  endfunction

  function automatic logic [AXIS_KIP_TUSER_WIDTH-1:0] mk_user(int src, logic [7:0] tag);
    return (src == 0) ? 64'hFEFE_CDCD_1212_1212 : {24'h000100, tag, 32'hC0A8_0001};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected beats of one packet (count may stop short for a discarded packet).
  task automatic push_pkt(input int src, input int nbeats, input logic [7:0] tag,
                          input int count);
    exp_t e;
    for (int b = 0; b < count; b++) begin
      e.l = (b == nbeats - 1);
      e.d = mk_data(src, tag, b);
      e.k = mk_keep(e.l);
      e.u = mk_user(src, tag);
      exp_q.push_back(e);
    end
  endtask

  // Drive n_send beats of an nbeats packet; optional tvalid gap after beat gap_after.
  task automatic send_pkt(input int src, input int nbeats, input logic [7:0] tag,
                          input int gap_after, input int gap_len, input int n_send);
    int to;
    for (int b = 0; b < n_send; b++) begin
      drv_valid[src] = 1'b1;
      drv_last[src]  = (b == nbeats - 1);
      drv_data[src]  = mk_data(src, tag, b);
      drv_keep[src]  = mk_keep(b == nbeats - 1);
      drv_user[src]  = mk_user(src, tag);
      to = 0;
      forever begin
        @(negedge clk);
        if (rdy[src]) break;
        to++;
        if (to > 300) break;
      end
      if (to > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout src=%0d: tready got 0, expected 1", src);
        drv_valid[src] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      drv_valid[src] = 1'b0;
      if (gap_after == b + 1) repeat (gap_len) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_tvalid"}, 64'(k_if.tvalid), 64'd0);
    chk({pfx, "_tdata"}, 64'(k_if.tdata != '0), 64'd0);
    chk({pfx, "_tkeep"}, k_if.tkeep, 64'd0);
    chk({pfx, "_tuser"}, k_if.tuser, 64'd0);
    chk({pfx, "_tlast"}, 64'(k_if.tlast), 64'd0);
    chk({pfx, "_gs_tready"}, 64'(gs_if.tready), 64'd0);
    chk({pfx, "_nb_tready"}, 64'(nb_if.tready), 64'd0);
    chk({pfx, "_gs_cnt"}, 64'(gs_cnt), 64'd0);
    chk({pfx, "_nb_cnt"}, 64'(nb_cnt), 64'd0);
  endtask

  // Monitor: every kernel-side transfer is popped from the scoreboard; a stalled beat
  // must still be presented unchanged on the next cycle.
  logic                       held_pend = 1'b0;
  logic [AXIS_DATA_WIDTH-1:0] held_d;
  logic                       held_l;
  always @(negedge clk) begin
    exp_t e;
    if (held_pend && !rst) begin
      n_cmp++;
      if (!k_if.tvalid || k_if.tdata !== held_d || k_if.tlast !== held_l) begin
        n_err++;
        $display("FAIL hold_stable: got valid=%0b data=%0h last=%0b, expected valid=1 data=%0h last=%0b",
                 k_if.tvalid, k_if.tdata[63:0], k_if.tlast, held_d[63:0], held_l);
      end
    end
    held_pend = k_if.tvalid && !k_if.tready && !rst;
    held_d    = k_if.tdata;
    held_l    = k_if.tlast;
    if (k_if.tvalid && k_if.tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got data=%0h, expected no beat", k_if.tdata[63:0]);
      end else begin
        e = exp_q.pop_front();
        if (k_if.tdata !== e.d || k_if.tkeep !== e.k || k_if.tuser !== e.u ||
            k_if.tlast !== e.l) begin
          n_err++;
          $display("FAIL beat: got d=%0h k=%0h u=%0h l=%0b, expected d=%0h k=%0h u=%0h l=%0b",
                   k_if.tdata, k_if.tkeep, k_if.tuser, k_if.tlast, e.d, e.k, e.u, e.l);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation got no end, expected $finish");
    $fatal(1);
  end

  initial begin
    logic gs_done;
    logic bp_done;
    for (int s = 0; s < 2; s++) begin
      drv_valid[s] = 1'b0;
      drv_data[s]  = '0;
      drv_keep[s]  = '0;
      drv_user[s]  = '0;
      drv_last[s]  = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("por");

    // Single GS packet with arbitration latency check.
    push_pkt(0, 3, 8'h11, 3);
    fork
      begin
        send_pkt(0, 3, 8'h11, 0, 0, 3);
        chk("single_gs_cnt_after_tlast", 64'(gs_cnt), 64'd1);
      end
      begin
        @(posedge clk);
        #1;
        chk("lat_n1_tvalid", 64'(k_if.tvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_n2_tvalid", 64'(k_if.tvalid), 64'd1);
      end
    join
    drain("single_gs_drain");
    chk("single_nb_cnt", 64'(nb_cnt), 64'd0);

    // Tie, two rounds, from a fresh round-robin state.
    do_reset();
    push_pkt(0, 2, 8'h21, 2);
    push_pkt(1, 2, 8'h31, 2);
    push_pkt(0, 2, 8'h22, 2);
    push_pkt(1, 2, 8'h32, 2);
    fork
      begin
        send_pkt(0, 2, 8'h21, 0, 0, 2);
        send_pkt(0, 2, 8'h22, 0, 0, 2);
      end
      begin
        send_pkt(1, 2, 8'h31, 0, 0, 2);
        send_pkt(1, 2, 8'h32, 0, 0, 2);
      end
    join
    drain("tie_drain");
    chk("tie_gs_cnt", 64'(gs_cnt), 64'd2);
    chk("tie_nb_cnt", 64'(nb_cnt), 64'd2);

    // Backpressure: kernel tready toggles every cycle during a 4-beat NB packet.
    push_pkt(1, 4, 8'h41, 4);
    bp_done = 1'b0;
    fork
      begin
        send_pkt(1, 4, 8'h41, 0, 0, 4);
        bp_done = 1'b1;
      end
      begin
        for (int i = 0; i < 200 && !(bp_done && exp_q.size() == 0); i++) begin
          @(posedge clk);
          #1;
          kready = ~kready;
        end
        kready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_nb_cnt", 64'(nb_cnt), 64'd3);

    // Mid-packet gap on GS while NB is waiting.
    push_pkt(0, 3, 8'h51, 3);
    push_pkt(1, 1, 8'h61, 1);
    gs_done = 1'b0;
    fork
      begin
        send_pkt(0, 3, 8'h51, 1, 5, 3);
        gs_done = 1'b1;
      end
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        send_pkt(1, 1, 8'h61, 0, 0, 1);
      end
      begin
        while (!gs_done) begin
          @(negedge clk);
          if (drv_valid[1] && !gs_done) chk("gap_nb_tready", 64'(nb_if.tready), 64'd0);
        end
      end
    join
    drain("gap_drain");
    chk("gap_gs_cnt", 64'(gs_cnt), 64'd3);
    chk("gap_nb_cnt", 64'(nb_cnt), 64'd4);

    // Reset after beat 2 of a 4-beat GS packet; beat 2 still reaches the kernels.
    push_pkt(0, 4, 8'h71, 2);
    send_pkt(0, 4, 8'h71, 0, 0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("midrst");
    chk("midrst_partial_delivered", 64'(exp_q.size()), 64'd0);
    push_pkt(1, 2, 8'h81, 2);
    send_pkt(1, 2, 8'h81, 0, 0, 2);
    drain("midrst_after_drain");
    chk("midrst_after_nb_cnt", 64'(nb_cnt), 64'd1);
    chk("midrst_after_gs_cnt", 64'(gs_cnt), 64'd0);

    // Counter wrap: 17 single-beat NB packets on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push_pkt(1, 1, 8'(8'h90 + i), 1);
      send_pkt(1, 1, 8'(8'h90 + i), 0, 0, 1);
    end
    drain("wrap_drain");
    chk("wrap_nb_cnt", 64'(nb_cnt), 64'd1);
    chk("wrap_gs_cnt", 64'(gs_cnt), 64'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
